// File: rtl/mac_accum_sequencer.sv
// mac_accum_sequencer
// Operand-side controller for a combinational FP32 fused multiply-add unit
// (Result = A + B*C). Streams (B, C) pairs into the unit, lets the
// combinational path settle for PARM_MAC_LAT cycles, then folds the result
// back into the accumulator that drives the unit's A input. The final sum
// is offered on a valid/ready result channel.
//
// Handshakes: a transfer happens on a rising clk_i edge where both valid
// and ready are high. Op_ready_o depends only on state (high in LOAD);
// Res_valid_o depends only on state (high in DONE) and Res_o is held
// stable until Res_ready_i is seen.
//
// Optional build macro: MACSEQ_NAN_SKIP_EN. When defined, pairs accepted
// while the accumulator already holds a NaN skip the settle wait and drain
// at one per cycle, leaving the accumulator untouched.

module mac_accum_sequencer #(
    parameter int PARM_XLEN    = 32,
    parameter int PARM_LEN_W   = 8,
    parameter int PARM_MAC_LAT = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  Start_i,
    input  logic [PARM_LEN_W-1:0] Len_i,
    input  logic [PARM_XLEN-1:0]  Init_i,
    output logic                  Busy_o,
    input  logic                  Op_valid_i,
    output logic                  Op_ready_o,
    input  logic [PARM_XLEN-1:0]  OpB_i,
    input  logic [PARM_XLEN-1:0]  OpC_i,
    output logic [PARM_XLEN-1:0]  Mac_A_o,
    output logic [PARM_XLEN-1:0]  Mac_B_o,
    output logic [PARM_XLEN-1:0]  Mac_C_o,
    input  logic [PARM_XLEN-1:0]  Mac_Result_i,
    output logic                  Res_valid_o,
    input  logic                  Res_ready_i,
    output logic [PARM_XLEN-1:0]  Res_o,
    output logic [PARM_LEN_W-1:0] Count_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Settle count loaded on every accept; 4 bits covers the 1..15 range.
    localparam logic [3:0] MAC_LAT = 4'(PARM_MAC_LAT);

    state_t                state;
    state_t                state_next;
    logic [PARM_XLEN-1:0]  acc;
    logic [PARM_XLEN-1:0]  mac_b;
    logic [PARM_XLEN-1:0]  mac_c;
    logic [PARM_LEN_W-1:0] count;
    logic [PARM_LEN_W-1:0] remaining;
    logic [3:0]            wait_cnt;

    logic op_fire;
    logic last_pair;
    logic settle_done;

    assign op_fire     = (state == ST_LOAD) && Op_valid_i;
    assign last_pair   = (remaining == PARM_LEN_W'(1));
    assign settle_done = (wait_cnt == 4'd1);

`ifdef MACSEQ_NAN_SKIP_EN
    // FP32 NaN: exponent all ones, mantissa non-zero.
    logic acc_is_nan;
    assign acc_is_nan = (acc[30:23] == 8'hFF) && (acc[22:0] != 23'd0);
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and state-derived handshake outputs.
    always_comb begin
        state_next  = state;
        Op_ready_o  = 1'b0;
        Res_valid_o = 1'b0;
        Busy_o      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (Start_i) begin
                    state_next = (Len_i == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                Op_ready_o = 1'b1;
                if (op_fire) begin
`ifdef MACSEQ_NAN_SKIP_EN
                    if (acc_is_nan) begin
                        state_next = last_pair ? ST_DONE : ST_LOAD;
                    end else begin
                        state_next = ST_EXEC;
                    end
`else
                    state_next = ST_EXEC;
`endif
                end
            end
            ST_EXEC: begin
                if (settle_done) begin
                    state_next = last_pair ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                Res_valid_o = 1'b1;
                if (Res_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: accumulator, FMA operand latches and counters.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc       <= '0;
            mac_b     <= '0;
            mac_c     <= '0;
            count     <= '0;
            remaining <= '0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start_i) begin
                        acc       <= Init_i;
                        remaining <= Len_i;
                        count     <= '0;
                    end
                end
                ST_LOAD: begin
                    if (Op_valid_i) begin
                        mac_b <= OpB_i;
                        mac_c <= OpC_i;
`ifdef MACSEQ_NAN_SKIP_EN
                        if (acc_is_nan) begin
                            remaining <= remaining - PARM_LEN_W'(1);
                            count     <= count + PARM_LEN_W'(1);
                        end else begin
                            wait_cnt <= MAC_LAT;
                        end
`else
                        wait_cnt <= MAC_LAT;
`endif
                    end
                end
                ST_EXEC: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (settle_done) begin
                        acc       <= Mac_Result_i;
                        remaining <= remaining - PARM_LEN_W'(1);
                        count     <= count + PARM_LEN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Mac_A_o = acc;
    assign Mac_B_o = mac_b;
    assign Mac_C_o = mac_c;
    assign Res_o   = acc;
    assign Count_o = count;

endmodule

// File: tb/tb_mac_accum_sequencer.sv
// Directed bench for mac_accum_sequencer (default parameters, settle = 2).
// The FMA unit is stood in for by the bench: Mac_Result_i is driven with a
// hand-computed FP32 value for each pair. Inputs are driven and outputs are
// observed at the falling clock edge.

module tb_mac_accum_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        Start_i;
    logic [7:0]  Len_i;
    logic [31:0] Init_i;
    logic        Busy_o;
    logic        Op_valid_i;
    logic        Op_ready_o;
    logic [31:0] OpB_i;
    logic [31:0] OpC_i;
    logic [31:0] Mac_A_o;
    logic [31:0] Mac_B_o;
    logic [31:0] Mac_C_o;
    logic [31:0] Mac_Result_i;
    logic        Res_valid_o;
    logic        Res_ready_i;
    logic [31:0] Res_o;
    logic [7:0]  Count_o;

    int n_total = 0;
    int n_pass  = 0;

    mac_accum_sequencer dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .Start_i      (Start_i),
        .Len_i        (Len_i),
        .Init_i       (Init_i),
        .Busy_o       (Busy_o),
        .Op_valid_i   (Op_valid_i),
        .Op_ready_o   (Op_ready_o),
        .OpB_i        (OpB_i),
        .OpC_i        (OpC_i),
        .Mac_A_o      (Mac_A_o),
        .Mac_B_o      (Mac_B_o),
        .Mac_C_o      (Mac_C_o),
        .Mac_Result_i (Mac_Result_i),
        .Res_valid_o  (Res_valid_o),
        .Res_ready_i  (Res_ready_i),
        .Res_o        (Res_o),
        .Count_o      (Count_o)
    );

    // Clock and watchdog.
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_op_ready"}, 32'(Op_ready_o), 32'd0);
        chk({tag, "_res_valid"}, 32'(Res_valid_o), 32'd0);
        chk({tag, "_busy"}, 32'(Busy_o), 32'd0);
        chk({tag, "_mac_a"}, Mac_A_o, 32'd0);
        chk({tag, "_mac_b"}, Mac_B_o, 32'd0);
        chk({tag, "_mac_c"}, Mac_C_o, 32'd0);
        chk({tag, "_res"}, Res_o, 32'd0);
        chk({tag, "_count"}, 32'(Count_o), 32'd0);
    endtask

    initial begin
        rst_ni       = 1'b0;
        Start_i      = 1'b0;
        Len_i        = 8'd0;
        Init_i       = 32'd0;
        Op_valid_i   = 1'b0;
        OpB_i        = 32'd0;
        OpC_i        = 32'd0;
        Mac_Result_i = 32'd0;
        Res_ready_i  = 1'b0;

        // ---- reset ----
        tick();
        tick();
        chk_idle_zero("reset");
        rst_ni = 1'b1;

        // ---- basic run: 0 + 1*2 + 3*4 + 0.5*2 = 15.0 ----
        Start_i = 1'b1; Len_i = 8'd3; Init_i = 32'h0000_0000;
        tick();
        Start_i = 1'b0;
        chk("load1_ready", 32'(Op_ready_o), 32'd1);
        chk("load1_busy", 32'(Busy_o), 32'd1);
        chk("load1_count", 32'(Count_o), 32'd0);
        Op_valid_i = 1'b1; OpB_i = 32'h3F80_0000; OpC_i = 32'h4000_0000;
        Mac_Result_i = 32'h4000_0000;                   // 0 + 1*2 = 2.0
        tick();                                         // accept pair 1
        Op_valid_i = 1'b0;
        chk("exec1_ready", 32'(Op_ready_o), 32'd0);
        chk("exec1_mac_b", Mac_B_o, 32'h3F80_0000);
        chk("exec1_mac_c", Mac_C_o, 32'h4000_0000);
        tick();
        chk("exec1b_ready", 32'(Op_ready_o), 32'd0);
        tick();                                         // capture pair 1
        chk("load2_ready", 32'(Op_ready_o), 32'd1);
        chk("load2_mac_a", Mac_A_o, 32'h4000_0000);
        chk("load2_count", 32'(Count_o), 32'd1);

        // ---- latency: Op_valid held high, ready every 3 cycles ----
        Op_valid_i = 1'b1; OpB_i = 32'h4040_0000; OpC_i = 32'h4080_0000;
        Mac_Result_i = 32'h4160_0000;                   // 2 + 3*4 = 14.0
        tick();                                         // accept pair 2
        chk("exec2_ready", 32'(Op_ready_o), 32'd0);
        chk("exec2_mac_b", Mac_B_o, 32'h4040_0000);
        chk("exec2_mac_c", Mac_C_o, 32'h4080_0000);
        OpB_i = 32'h3F00_0000; OpC_i = 32'h4000_0000;   // next pair waits
        tick();
        chk("exec2b_ready", 32'(Op_ready_o), 32'd0);
        chk("exec2b_mac_b_hold", Mac_B_o, 32'h4040_0000);
        tick();                                         // capture pair 2
        chk("load3_ready", 32'(Op_ready_o), 32'd1);
        chk("load3_mac_a", Mac_A_o, 32'h4160_0000);
        chk("load3_count", 32'(Count_o), 32'd2);
        chk("load3_mac_b_hold", Mac_B_o, 32'h4040_0000);
        Mac_Result_i = 32'h4170_0000;                   // 14 + 0.5*2 = 15.0
        tick();                                         // accept pair 3
        chk("exec3_mac_b", Mac_B_o, 32'h3F00_0000);
        chk("exec3_mac_c", Mac_C_o, 32'h4000_0000);
        Op_valid_i = 1'b0;
        tick();
        tick();                                         // capture -> DONE
        chk("done_valid", 32'(Res_valid_o), 32'd1);
        chk("done_res", Res_o, 32'h4170_0000);
        chk("done_count", 32'(Count_o), 32'd3);
        chk("done_ready", 32'(Op_ready_o), 32'd0);

        // ---- backpressure: 5 cycles without Res_ready, Start ignored ----
        for (int i = 0; i < 5; i++) begin
            Start_i = (i == 1); Len_i = 8'd5; Init_i = 32'h1234_5678;
            tick();
            chk("bp_valid", 32'(Res_valid_o), 32'd1);
            chk("bp_res", Res_o, 32'h4170_0000);
            chk("bp_busy", 32'(Busy_o), 32'd1);
        end
        Start_i = 1'b0;
        Res_ready_i = 1'b1;
        tick();                                         // handshake -> IDLE
        Res_ready_i = 1'b0;
        chk("post_hs_valid", 32'(Res_valid_o), 32'd0);
        chk("post_hs_busy", 32'(Busy_o), 32'd0);
        chk("post_hs_mac_a", Mac_A_o, 32'h4170_0000);

        // ---- zero length ----
        Start_i = 1'b1; Len_i = 8'd0; Init_i = 32'h3F80_0000;
        tick();
        Start_i = 1'b0;
        chk("zlen_valid", 32'(Res_valid_o), 32'd1);
        chk("zlen_res", Res_o, 32'h3F80_0000);
        chk("zlen_count", 32'(Count_o), 32'd0);
        chk("zlen_mac_b", Mac_B_o, 32'h3F00_0000);
        chk("zlen_mac_c", Mac_C_o, 32'h4000_0000);
        chk("zlen_ready", 32'(Op_ready_o), 32'd0);
        Res_ready_i = 1'b1;
        tick();
        Res_ready_i = 1'b0;
        chk("zlen_idle", 32'(Busy_o), 32'd0);

        // ---- reset during EXEC of the second pair ----
        Start_i = 1'b1; Len_i = 8'd3; Init_i = 32'h0000_0000;
        tick();
        Start_i = 1'b0;
        Op_valid_i = 1'b1; OpB_i = 32'h3F80_0000; OpC_i = 32'h4000_0000;
        Mac_Result_i = 32'h4000_0000;
        tick();
        Op_valid_i = 1'b0;
        tick();
        tick();
        chk("rst_run_count", 32'(Count_o), 32'd1);
        Op_valid_i = 1'b1; OpB_i = 32'h4040_0000; OpC_i = 32'h4080_0000;
        Mac_Result_i = 32'h4160_0000;
        tick();                                         // in EXEC of pair 2
        Op_valid_i = 1'b0;
        chk("rst_run_exec", 32'(Op_ready_o), 32'd0);
        rst_ni = 1'b0;
        tick();
        chk_idle_zero("midrst");
        rst_ni = 1'b1;

        // ---- fresh run after reset: 1.0 + 2*3 = 7.0 ----
        Start_i = 1'b1; Len_i = 8'd1; Init_i = 32'h3F80_0000;
        tick();
        Start_i = 1'b0;
        chk("rerun_ready", 32'(Op_ready_o), 32'd1);
        chk("rerun_mac_a", Mac_A_o, 32'h3F80_0000);
        Op_valid_i = 1'b1; OpB_i = 32'h4000_0000; OpC_i = 32'h4040_0000;
        Mac_Result_i = 32'h40E0_0000;
        tick();
        Op_valid_i = 1'b0;
        tick();
        chk("rerun_not_done", 32'(Res_valid_o), 32'd0);
        tick();
        chk("rerun_valid", 32'(Res_valid_o), 32'd1);
        chk("rerun_res", Res_o, 32'h40E0_0000);
        chk("rerun_count", 32'(Count_o), 32'd1);
        Res_ready_i = 1'b1;
        tick();
        Res_ready_i = 1'b0;
        chk("rerun_idle", 32'(Busy_o), 32'd0);

        // ---- NaN accumulator: first pair produces NaN, three more follow ----
        Start_i = 1'b1; Len_i = 8'd4; Init_i = 32'h0000_0000;
        tick();
        Start_i = 1'b0;
        Op_valid_i = 1'b1; OpB_i = 32'h7FC0_0000; OpC_i = 32'h3F80_0000;
        Mac_Result_i = 32'h7FC0_0000;                   // 0 + NaN*1 = NaN
        tick();
        OpB_i = 32'h3F80_0000; OpC_i = 32'h3F80_0000;
        tick();
        tick();                                         // NaN captured, LOAD
        chk("nan_load_ready", 32'(Op_ready_o), 32'd1);
        chk("nan_load_acc", Mac_A_o, 32'h7FC0_0000);
        chk("nan_load_count", 32'(Count_o), 32'd1);
`ifdef MACSEQ_NAN_SKIP_EN
        for (int k = 2; k <= 3; k++) begin
            tick();
            chk("nan_skip_ready", 32'(Op_ready_o), 32'd1);
            chk("nan_skip_count", 32'(k), 32'(Count_o));
        end
        tick();
`else
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk("nan_exec_ready", 32'(Op_ready_o), 32'd0);
            tick();
            chk("nan_exec_count", 32'(Count_o), 32'(k - 1));
            tick();
        end
`endif
        Op_valid_i = 1'b0;
        chk("nan_done_valid", 32'(Res_valid_o), 32'd1);
        chk("nan_done_res", Res_o, 32'h7FC0_0000);
        chk("nan_done_count", 32'(Count_o), 32'd4);
        Res_ready_i = 1'b1;
        tick();
        Res_ready_i = 1'b0;
        chk("nan_idle", 32'(Busy_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
